// File: rtl/cpu_pkg.sv
// Shared types and sizes for the operand-fetch slice of the pipeline.
package cpu_pkg;
    localparam int unsigned NREGS   = 16;
    localparam int unsigned IDX_W   = 4;
    localparam int unsigned WORD_W  = 32;
    localparam int unsigned OP_W    = 8;
    localparam int unsigned STALL_W = 16;

    typedef logic [IDX_W-1:0]  reg_idx_t;
    typedef logic [WORD_W-1:0] word_t;
    typedef logic [OP_W-1:0]   op_t;
endpackage

// File: rtl/reg_scoreboard.sv
// Busy mask for in-flight register writes, with writeback-aware hot queries
// for four register indexes. Register 0 is never busy.
module reg_scoreboard #(
    parameter int unsigned NREGS = 16
) (
    input  logic                     clk,
    input  logic                     rst_async,
    input  logic                     clr_valid,
    input  cpu_pkg::reg_idx_t        clr_index,
    input  logic                     set_valid,
    input  cpu_pkg::reg_idx_t        set_index,
    input  cpu_pkg::reg_idx_t [3:0]  q_index,
    output logic [3:0]               hot
);
    import cpu_pkg::*;

    logic [NREGS-1:0] busy_q;
    logic [NREGS-1:0] busy_d;

    // Clear first, then set, so a same-cycle set on the cleared index wins.
    always_comb begin
        busy_d = busy_q;
        if (clr_valid) begin
            busy_d[clr_index] = 1'b0;
        end
        if (set_valid && (set_index != '0)) begin
            busy_d[set_index] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_comb begin
        hot = '0;
        for (int i = 0; i < 4; i++) begin
            hot[i] = busy_q[q_index[i]] && (q_index[i] != '0)
                     && !(clr_valid && (clr_index == q_index[i]));
        end
    end

    always_ff @(posedge clk or posedge rst_async) begin
        if (rst_async) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end
endmodule

// File: rtl/operand_fetch.sv
// Operand fetch stage: hazard check against the scoreboard, writeback bypass
// into the operands, and a single registered issue slot towards execute.
module operand_fetch #(
    parameter int unsigned OP_W  = 8,
    parameter int unsigned NREGS = 16
) (
    input  logic                            clk,
    input  logic                            rst_async,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic [OP_W-1:0]                 in_op,
    input  cpu_pkg::reg_idx_t               in_dst,
    input  cpu_pkg::reg_idx_t               in_src_a,
    input  cpu_pkg::reg_idx_t               in_src_b,
    input  cpu_pkg::reg_idx_t               in_src_c,
    input  logic                            in_writes,
    output cpu_pkg::reg_idx_t               rf_a_index,
    output cpu_pkg::reg_idx_t               rf_b_index,
    output cpu_pkg::reg_idx_t               rf_c_index,
    input  cpu_pkg::word_t                  rf_a,
    input  cpu_pkg::word_t                  rf_b,
    input  cpu_pkg::word_t                  rf_c,
    input  logic                            wb_valid,
    input  cpu_pkg::reg_idx_t               wb_index,
    input  cpu_pkg::word_t                  wb_data,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [OP_W-1:0]                 out_op,
    output cpu_pkg::reg_idx_t               out_dst,
    output logic                            out_writes,
    output cpu_pkg::word_t                  out_a,
    output cpu_pkg::word_t                  out_b,
    output cpu_pkg::word_t                  out_c,
    output logic [cpu_pkg::STALL_W-1:0]     stall_cycles
);
    import cpu_pkg::*;

    logic [3:0] hot;
    logic       hazard;
    logic       accept;

    logic                out_valid_q,  out_valid_d;
    logic [OP_W-1:0]     out_op_q,     out_op_d;
    reg_idx_t            out_dst_q,    out_dst_d;
    logic                out_writes_q, out_writes_d;
    word_t               out_a_q,      out_a_d;
    word_t               out_b_q,      out_b_d;
    word_t               out_c_q,      out_c_d;
    logic [STALL_W-1:0]  stall_q,      stall_d;

    function automatic word_t pick(input reg_idx_t src, input word_t rf,
                                   input logic wbv, input reg_idx_t wbi,
                                   input word_t wbd);
        if (src == '0) begin
            return '0;
        end
        if (wbv && (wbi == src)) begin
            return wbd;
        end
        return rf;
    endfunction

    assign rf_a_index = in_src_a;
    assign rf_b_index = in_src_b;
    assign rf_c_index = in_src_c;

    reg_scoreboard #(.NREGS(NREGS)) u_sb (
        .clk       (clk),
        .rst_async (rst_async),
        .clr_valid (wb_valid),
        .clr_index (wb_index),
        .set_valid (accept && in_writes),
        .set_index (in_dst),
        .q_index   ({in_dst, in_src_c, in_src_b, in_src_a}),
        .hot       (hot)
    );

    // Destination hotness only matters for instructions that write (WAW).
    assign hazard   = in_valid && (hot[0] || hot[1] || hot[2] || (in_writes && hot[3]));
    assign in_ready = !hazard && (!out_valid_q || out_ready);
    assign accept   = in_valid && in_ready;

    always_comb begin
        out_valid_d  = out_valid_q;
        out_op_d     = out_op_q;
        out_dst_d    = out_dst_q;
        out_writes_d = out_writes_q;
        out_a_d      = out_a_q;
        out_b_d      = out_b_q;
        out_c_d      = out_c_q;
        stall_d      = stall_q;
        if (accept) begin
            out_valid_d  = 1'b1;
            out_op_d     = in_op;
            out_dst_d    = in_dst;
            out_writes_d = in_writes;
            out_a_d      = pick(in_src_a, rf_a, wb_valid, wb_index, wb_data);
            out_b_d      = pick(in_src_b, rf_b, wb_valid, wb_index, wb_data);
            out_c_d      = pick(in_src_c, rf_c, wb_valid, wb_index, wb_data);
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
        if (hazard && (stall_q != {STALL_W{1'b1}})) begin
            stall_d = stall_q + STALL_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst_async) begin
        if (rst_async) begin
            out_valid_q  <= 1'b0;
            out_op_q     <= '0;
            out_dst_q    <= '0;
            out_writes_q <= 1'b0;
            out_a_q      <= '0;
            out_b_q      <= '0;
            out_c_q      <= '0;
            stall_q      <= '0;
        end else begin
            out_valid_q  <= out_valid_d;
            out_op_q     <= out_op_d;
            out_dst_q    <= out_dst_d;
            out_writes_q <= out_writes_d;
            out_a_q      <= out_a_d;
            out_b_q      <= out_b_d;
            out_c_q      <= out_c_d;
            stall_q      <= stall_d;
        end
    end

    assign out_valid    = out_valid_q;
    assign out_op       = out_op_q;
    assign out_dst      = out_dst_q;
    assign out_writes   = out_writes_q;
    assign out_a        = out_a_q;
    assign out_b        = out_b_q;
    assign out_c        = out_c_q;
    assign stall_cycles = stall_q;
endmodule

// File: tb/tb_operand_fetch.sv
// Scoreboard bench for operand_fetch: directed scenarios plus random traffic
// against a register-level reference model of issue, hazards and bypass.
module tb_operand_fetch;
    logic        clk = 1'b0;
    logic        rst_async;
    logic        in_valid, in_ready, in_writes;
    logic [7:0]  in_op;
    logic [3:0]  in_dst, in_src_a, in_src_b, in_src_c;
    logic [3:0]  rf_a_index, rf_b_index, rf_c_index;
    logic [31:0] rf_a, rf_b, rf_c;
    logic        wb_valid;
    logic [3:0]  wb_index;
    logic [31:0] wb_data;
    logic        out_valid, out_ready, out_writes;
    logic [7:0]  out_op;
    logic [3:0]  out_dst;
    logic [31:0] out_a, out_b, out_c;
    logic [15:0] stall_cycles;

    typedef struct {
        logic [7:0]  op;
        logic [3:0]  dst;
        logic        wr;
        logic [31:0] a, b, c;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] rf_mem [16];
    bit   [15:0] m_busy;
    bit          m_full;
    int          m_stall;
    bit          pend_wb;
    logic [3:0]  pend_idx;
    logic [31:0] pend_data;
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    assign rf_a = rf_mem[rf_a_index];
    assign rf_b = rf_mem[rf_b_index];
    assign rf_c = rf_mem[rf_c_index];

    operand_fetch dut (
        .clk(clk), .rst_async(rst_async),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
        .in_dst(in_dst), .in_src_a(in_src_a), .in_src_b(in_src_b), .in_src_c(in_src_c),
        .in_writes(in_writes),
        .rf_a_index(rf_a_index), .rf_b_index(rf_b_index), .rf_c_index(rf_c_index),
        .rf_a(rf_a), .rf_b(rf_b), .rf_c(rf_c),
        .wb_valid(wb_valid), .wb_index(wb_index), .wb_data(wb_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_op(out_op),
        .out_dst(out_dst), .out_writes(out_writes),
        .out_a(out_a), .out_b(out_b), .out_c(out_c),
        .stall_cycles(stall_cycles)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] operand(input logic [3:0] s, input bit wbv,
                                            input logic [3:0] wbi, input logic [31:0] wbd);
        if (s == 4'd0) return 32'd0;
        if (wbv && wbi == s) return wbd;
        return rf_mem[s];
    endfunction

    function automatic bit waits_on(input logic [3:0] r, input bit wbv, input logic [3:0] wbi);
        return m_busy[r] && r != 4'd0 && !(wbv && wbi == r);
    endfunction

    // One clock of stimulus; predicts the handshake and queues the issued instruction.
    task automatic step(input bit v, input logic [7:0] op, input logic [3:0] dst,
                        input logic [3:0] sa, input logic [3:0] sb, input logic [3:0] sc,
                        input bit wr, input bit wbv, input logic [3:0] wbi,
                        input logic [31:0] wbd, input bit ordy);
        bit   haz, rdy, acc;
        exp_t e;
        @(posedge clk);
        #1;
        if (pend_wb && pend_idx != 4'd0) rf_mem[pend_idx] = pend_data;
        pend_wb   = 1'b0;
        in_valid  = v;   in_op = op;  in_dst = dst;
        in_src_a  = sa;  in_src_b = sb; in_src_c = sc; in_writes = wr;
        wb_valid  = wbv; wb_index = wbi; wb_data = wbd;
        out_ready = ordy;
        #2;
        chk("rf_index", {rf_a_index, rf_b_index, rf_c_index}, {sa, sb, sc});
        chk("busy", 64'(dut.u_sb.busy_q), 64'(m_busy));
        chk("stall_cycles", 64'(stall_cycles), 64'(m_stall));
        chk("out_valid", 64'(out_valid), 64'(m_full));
        haz = v && (waits_on(sa, wbv, wbi) || waits_on(sb, wbv, wbi) ||
                    waits_on(sc, wbv, wbi) || (wr && waits_on(dst, wbv, wbi)));
        rdy = !haz && (!m_full || ordy);
        acc = v && rdy;
        chk("in_ready", 64'(in_ready), 64'(rdy));
        if (acc) begin
            e.op = op; e.dst = dst; e.wr = wr;
            e.a = operand(sa, wbv, wbi, wbd);
            e.b = operand(sb, wbv, wbi, wbd);
            e.c = operand(sc, wbv, wbi, wbd);
            exp_q.push_back(e);
        end
        m_full = acc ? 1'b1 : (ordy ? 1'b0 : m_full);
        if (haz && m_stall < 65535) m_stall++;
        if (wbv) m_busy[wbi] = 1'b0;
        if (acc && wr && dst != 4'd0) m_busy[dst] = 1'b1;
        if (wbv) begin
            pend_wb = 1'b1; pend_idx = wbi; pend_data = wbd;
        end
    endtask

    task automatic idle(input bit ordy);
        step(1'b0, 8'h00, 4'd0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 4'd0, 32'd0, ordy);
    endtask

    task automatic wb(input logic [3:0] idx, input logic [31:0] data);
        step(1'b0, 8'h00, 4'd0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b1, idx, data, 1'b1);
    endtask

    // Monitor: every completed issue handshake is matched against the queue.
    always @(negedge clk) begin
        exp_t e;
        if (!rst_async && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_issue: got op %0h with nothing expected at %0t", out_op, $time);
            end else begin
                e = exp_q.pop_front();
                chk("out_op", 64'(out_op), 64'(e.op));
                chk("out_dst", 64'(out_dst), 64'(e.dst));
                chk("out_writes", 64'(out_writes), 64'(e.wr));
                chk("out_a", 64'(out_a), 64'(e.a));
                chk("out_b", 64'(out_b), 64'(e.b));
                chk("out_c", 64'(out_c), 64'(e.c));
            end
        end
    end

    initial begin
        rst_async = 1'b1;
        in_valid = 1'b0; in_op = '0; in_dst = '0; in_src_a = '0; in_src_b = '0;
        in_src_c = '0; in_writes = 1'b0; wb_valid = 1'b0; wb_index = '0;
        wb_data = '0; out_ready = 1'b1;
        m_busy = '0; m_full = 1'b0; m_stall = 0; pend_wb = 1'b0;
        pend_idx = '0; pend_data = '0;
        for (int i = 0; i < 16; i++) rf_mem[i] = $urandom;
        rf_mem[0] = 32'hDEAD;
        rf_mem[1] = 32'd5;
        rf_mem[2] = 32'd7;
        #2;
        chk("reset_out_valid", 64'(out_valid), 64'd0);
        chk("reset_stall", 64'(stall_cycles), 64'd0);
        chk("reset_out_a", 64'(out_a), 64'd0);
        chk("reset_in_ready", 64'(in_ready), 64'd1);
        repeat (2) @(posedge clk);
        #3 rst_async = 1'b0;

        // add r3 <- r1, r2
        step(1'b1, 8'h01, 4'd3, 4'd1, 4'd2, 4'd0, 1'b1, 1'b0, 4'd0, 32'd0, 1'b1);
        // r4 <- r3 stalls until r3 writes back, then takes the bypassed value
        repeat (3) step(1'b1, 8'h02, 4'd4, 4'd3, 4'd0, 4'd0, 1'b1, 1'b0, 4'd0, 32'd0, 1'b1);
        step(1'b1, 8'h02, 4'd4, 4'd3, 4'd0, 4'd0, 1'b1, 1'b1, 4'd3, 32'd12, 1'b1);
        wb(4'd4, 32'h44);
        // r0 sources read as zero; r0 destination never becomes busy
        step(1'b1, 8'h03, 4'd0, 4'd0, 4'd0, 4'd1, 1'b1, 1'b0, 4'd0, 32'd0, 1'b1);
        // back-pressure: pending instruction waits, no hazard stalls counted
        step(1'b1, 8'h04, 4'd6, 4'd1, 4'd2, 4'd3, 1'b0, 1'b0, 4'd0, 32'd0, 1'b1);
        repeat (3) step(1'b1, 8'h05, 4'd7, 4'd2, 4'd1, 4'd0, 1'b0, 1'b0, 4'd0, 32'd0, 1'b0);
        step(1'b1, 8'h05, 4'd7, 4'd2, 4'd1, 4'd0, 1'b0, 1'b0, 4'd0, 32'd0, 1'b1);
        // set wins over same-cycle clear, then WAW stall on r5
        step(1'b1, 8'h06, 4'd5, 4'd0, 4'd0, 4'd0, 1'b1, 1'b0, 4'd0, 32'd0, 1'b1);
        step(1'b1, 8'h07, 4'd5, 4'd1, 4'd0, 4'd0, 1'b1, 1'b1, 4'd5, 32'h55, 1'b1);
        repeat (2) step(1'b1, 8'h08, 4'd5, 4'd2, 4'd0, 4'd0, 1'b1, 1'b0, 4'd0, 32'd0, 1'b1);
        step(1'b1, 8'h08, 4'd5, 4'd2, 4'd0, 4'd0, 1'b1, 1'b1, 4'd5, 32'h66, 1'b1);
        wb(4'd5, 32'h77);
        wb(4'd0, 32'h99);

        // Fill busy with r4..r7 and hold an instruction, then reset mid-cycle.
        for (int r = 4; r < 8; r++)
            step(1'b1, 8'h10, 4'(r), 4'd0, 4'd0, 4'd0, 1'b1, 1'b0, 4'd0, 32'd0, 1'b1);
        @(posedge clk);
        #1;
        in_valid = 1'b0; wb_valid = 1'b0; out_ready = 1'b0;
        #2;
        chk("pre_reset_busy", 64'(dut.u_sb.busy_q), 64'h00F0);
        chk("pre_reset_out_valid", 64'(out_valid), 64'd1);
        rst_async = 1'b1;
        #1;
        chk("async_out_valid", 64'(out_valid), 64'd0);
        chk("async_busy", 64'(dut.u_sb.busy_q), 64'd0);
        chk("async_stall", 64'(stall_cycles), 64'd0);
        chk("async_out_fields", {out_op, out_dst, out_writes, out_a[15:0]}, 64'd0);
        exp_q.delete();
        m_busy = '0; m_full = 1'b0; m_stall = 0;
        @(posedge clk);
        #3 rst_async = 1'b0;
        idle(1'b1);

        // Random traffic; writebacks mostly target registers that are in flight.
        for (int n = 0; n < 2000; n++) begin
            bit          v, wr, wbv, ordy;
            logic [3:0]  wbi;
            v    = ($urandom_range(0, 9) < 7);
            wr   = $urandom_range(0, 1) == 1;
            wbv  = $urandom_range(0, 1) == 1;
            ordy = ($urandom_range(0, 3) != 0);
            wbi  = 4'($urandom_range(0, 15));
            if (wbv && m_busy != 0 && $urandom_range(0, 3) != 0) begin
                while (!m_busy[wbi]) wbi = 4'($urandom_range(1, 15));
            end
            step(v, 8'($urandom), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), wr,
                 wbv, wbi, $urandom, ordy);
        end

        for (int r = 1; r < 16; r++) wb(4'(r), $urandom);
        repeat (3) idle(1'b1);
        chk("drain_queue_empty", 64'(exp_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
